// File: rtl/tse_init_seq.sv
// Table-driven TSE MAC register initialisation sequencer.
// Walks an external ADDR/DATA/MASK/OP step table and issues one Avalon-MM access per step.
module tse_init_seq #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int STEP_W      = 5,
    parameter int POLL_LIMIT  = 1024,
    parameter int TIMEOUT     = 4096,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_REINIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] ADR_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic [DATA_W-1:0] DAT_O,
    output logic              RD,
    output logic              WR,
    input  logic              BUSY,
    output logic [STEP_W-1:0] step_idx,
    input  logic [1:0]        step_op,
    input  logic [ADDR_W-1:0] step_addr,
    input  logic [DATA_W-1:0] step_data,
    input  logic [DATA_W-1:0] step_mask,
    input  logic              led_link,
    output logic              mac_inited,
    output logic              init_error,
    output logic [STEP_W-1:0] err_step,
    output logic [1:0]        retry_cnt
);

    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_WAIT_LINK,
        S_FETCH,
        S_ACCESS,
        S_CHECK,
        S_FAIL,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_VERIFY = 2'b01,
        OP_POLL   = 2'b10,
        OP_END    = 2'b11
    } op_t;

    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_mask;
    logic [DATA_W-1:0]   r_rdata;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   r_err_step;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [1:0]          r_retry;
    logic                r_inited;
    logic                r_error;

    logic w_rd;
    logic w_wr;
    logic w_xfer_done;
    logic w_match;
    logic w_step_inc;
    logic w_poll_inc;
    logic w_retry_ok;
    logic w_relink;

    assign w_xfer_done = (r_state == S_ACCESS) && !BUSY;
    assign w_match     = ((r_rdata ^ r_data) & r_mask) == '0;
    assign w_retry_ok  = r_retry < RETRY_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT_LINK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_inc  = 1'b0;
        w_poll_inc  = 1'b0;
        w_relink    = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_WAIT_LINK: begin
                if (led_link) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = (op_t'(step_op) == OP_END) ? S_DONE : S_ACCESS;
            end
            S_ACCESS: begin
                // Bus strobes follow the latched op only, so RD and WR are exclusive.
                w_wr = (r_op == OP_WRITE);
                w_rd = (r_op != OP_WRITE);
                if (!BUSY) begin
                    w_state_nxt = S_CHECK;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_CHECK: begin
                case (r_op)
                    OP_WRITE: begin
                        w_step_inc  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    OP_VERIFY: begin
                        if (w_match) begin
                            w_step_inc  = 1'b1;
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end
                    OP_POLL: begin
                        if (w_match) begin
                            w_step_inc  = 1'b1;
                            w_state_nxt = S_FETCH;
                        end else if (r_poll_cnt == POLL_LAST) begin
                            w_state_nxt = S_FAIL;
                        end else begin
                            w_poll_inc  = 1'b1;
                            w_state_nxt = S_ACCESS;
                        end
                    end
                    default: w_state_nxt = S_FETCH;
                endcase
            end
            S_FAIL: begin
                w_state_nxt = w_retry_ok ? S_FETCH : S_ERROR;
            end
            S_DONE: begin
                if ((AUTO_REINIT != 0) && !led_link) begin
                    w_relink    = 1'b1;
                    w_state_nxt = S_WAIT_LINK;
                end
            end
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_WAIT_LINK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= OP_WRITE;
            r_addr     <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_rdata    <= '0;
            r_step     <= '0;
            r_err_step <= '0;
            r_poll_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_retry    <= '0;
            r_inited   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_op       <= op_t'(step_op);
                r_addr     <= step_addr;
                r_data     <= step_data;
                r_mask     <= step_mask;
                r_poll_cnt <= '0;
            end
            if (w_poll_inc) r_poll_cnt <= r_poll_cnt + 1'b1;

            // Stall budget is per access: a reissued poll read starts a fresh count.
            if (r_state != S_ACCESS) begin
                r_tmo_cnt <= '0;
            end else if (BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_xfer_done) r_rdata <= DAT_I;
            if (w_step_inc) r_step <= r_step + 1'b1;

            if (r_state == S_FAIL) begin
                r_err_step <= r_step;
                if (w_retry_ok) begin
                    r_retry <= r_retry + 1'b1;
                    r_step  <= '0;
                end
            end

            if (w_relink) begin
                r_step  <= '0;
                r_retry <= '0;
            end

            r_inited <= (w_state_nxt == S_DONE);
            r_error  <= (w_state_nxt == S_ERROR);
        end
    end

    assign ADR_O      = r_addr;
    assign DAT_O      = r_data;
    assign RD         = w_rd;
    assign WR         = w_wr;
    assign step_idx   = r_step;
    assign mac_inited = r_inited;
    assign init_error = r_error;
    assign err_step   = r_err_step;
    assign retry_cnt  = r_retry;

endmodule

// File: doc/tse_init_seq.md
Name: tse_init_seq

Overview:
- Table-driven register initialisation sequencer for the TSE MAC, and the parametrised successor of the fixed MAC init path.
- Walks an external step table of ADDR/DATA/MASK/OP entries. Each step drives one Avalon-MM master access: write, read-verify, or poll-until-match.
- Reports mac_inited on completion; otherwise reports an error with the failing step index.
- Supports bus-stall timeout, whole-sequence retry, and automatic re-initialisation on link loss. Sits between the top level and the MAC management slave.

Parameters:
- ADDR_W, 10, Avalon address width.
- DATA_W, 32, Avalon data width.
- STEP_W, 5, step index width (max 2^STEP_W table entries).
- POLL_LIMIT, 1024, max reads per POLL step before failure.
- TIMEOUT, 4096, max cycles BUSY may stall one access.
- MAX_RETRY, 3, sequence restarts allowed after a failure.
- AUTO_REINIT, 1, 1 = restart sequence when led_link falls after init.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ADR_O  out  ADDR_W  Avalon address.
- DAT_I  in  DATA_W  Avalon read data.
- DAT_O  out  DATA_W  Avalon write data.
- RD  out  1  Avalon read.
- WR  out  1  Avalon write.
- BUSY  in  1  Avalon waitrequest.
- step_idx  out  STEP_W  table read address.
- step_op  in  2  00 WRITE, 01 VERIFY, 10 POLL, 11 END; valid 1 cycle after step_idx changes.
- step_addr  in  ADDR_W  step address, same timing as step_op.
- step_data  in  DATA_W  write data or expected value.
- step_mask  in  DATA_W  compare mask.
- led_link  in  1  PHY link indication.
- mac_inited  out  1  sequence completed, held high.
- init_error  out  1  sticky failure after retries exhausted.
- err_step  out  STEP_W  index of last failing step.
- retry_cnt  out  2  retries consumed.

Behaviour:
- Reset: all outputs 0, state WAIT_LINK, step_idx=0.
- Reset asserted mid-access drops RD/WR in the next cycle; no further bus activity.
- WAIT_LINK -> FETCH when led_link=1.
- FETCH: 1 cycle for table latency; latches op/addr/data/mask.
  - END -> DONE.
  - Otherwise -> ACCESS.
- ACCESS:
  - ADR_O = latched addr.
  - WR=1 with DAT_O=data for WRITE; RD=1 otherwise.
  - ADR_O, DAT_O, RD and WR are held stable while BUSY=1.
  - A transfer completes on the first cycle with (RD|WR)=1 and BUSY=0; DAT_I is sampled in that cycle.
  - RD/WR deassert the following cycle; minimum one idle cycle between accesses.
- Stall timeout: a per-access counter counts BUSY cycles. Reaching TIMEOUT drops RD/WR and goes to FAIL.
- CHECK, applied to the completed access:
  - WRITE: step_idx+1 -> FETCH.
  - VERIFY: (DAT_I & mask)==(data & mask) -> next step; else FAIL.
  - POLL on match: next step.
  - POLL on mismatch: increment poll counter and reissue the read. Failure when the counter reaches POLL_LIMIT reads, i.e. POLL_LIMIT mismatches -> FAIL.
  - Poll counter clears at each new step.
- FAIL:
  - err_step = current step_idx.
  - If retry_cnt<MAX_RETRY: retry_cnt+1, step_idx=0 -> FETCH.
  - Else -> ERROR.
- DONE: mac_inited=1 from the cycle after END is fetched.
- Link loss: if AUTO_REINIT=1 and led_link=0 in DONE, then mac_inited=0 next cycle, step_idx=0, retry_cnt=0 -> WAIT_LINK.
- Link drop during the sequence is ignored; the sequence completes.
- ERROR: init_error=1, mac_inited=0, no bus activity, sticky until reset.
- step_idx wraps modulo 2^STEP_W if no END is encountered; this is a table fault and the sequence continues.
- The read/write choice comes only from the latched op; WR and RD are never high together.

Test Plan:
- Table {WRITE 0x02=0x0000_0003, WRITE 0x03=0x1122_3344, END}, BUSY=0, led_link=1:
  - exactly 2 writes with those addr/data;
  - mac_inited=1;
  - init_error=0.
- Same table, BUSY high 5 cycles on the first write: ADR_O/DAT_O/WR stable for 6 cycles; one write counted; completes normally.
- POLL 0x02 mask 0x2000 expect 0x0000, DAT_I bit13=1 for 7 reads then 0:
  - 8 reads issued;
  - step advances;
  - mac_inited=1.
- VERIFY 0x00 expect 0x0009_0900, DAT_I returns 0, MAX_RETRY=3:
  - 4 full sequence attempts;
  - init_error=1, err_step=0, retry_cnt=3;
  - no bus activity thereafter.
- BUSY held high, TIMEOUT=16:
  - RD/WR drop after 16 stall cycles;
  - retry starts at step 0.
- Init done, led_link 1->0: mac_inited=0 next cycle. Then led_link=1: sequence re-runs, mac_inited=1 again. With AUTO_REINIT=0, mac_inited stays 1.
